clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider for the amp_if clock tree.
- Each of NCH channels divides clk_in by a runtime-programmable integer D, with near-50% duty and a one-cycle rising-edge tick.
- New divisors take effect only at a period boundary, so there are no runt pulses.
- A common sync input phase-aligns all channels, e.g. bit clock and frame clock.
- Outputs are registered in the clk_in domain.

Parameters:
- NCH, 2, number of independent divider channels.
- CW, 8, divisor and counter width per channel; legal D range is 2..2^CW-1.
- DEF_DIV, 64, divisor loaded into every channel at reset; must satisfy 2 <= DEF_DIV <= 2^CW-1.

Ports:
- clk_in  input  1  master clock; all logic on its rising edge.
- resetb  input  1  reset, synchronous, active-low.
- en  input  1  global run enable; 0 freezes all channels.
- sync  input  1  single-cycle restart of all channels in phase.
- load  input  1  single-cycle strobe; captures div_in into the shadow registers.
- div_in  input  NCH*CW  divisor for channel i in bits [i*CW +: CW].
- clk_out  output  NCH  divided clock per channel, registered.
- tick  output  NCH  one clk_in-cycle pulse coincident with each clk_out rising edge.
- pending  output  NCH  shadow divisor captured but not yet active.

Behaviour:
- Per-channel state: active divisor D, shadow divisor S, pending flag P, phase counter cnt (CW bits), clk_out, tick.
- Reset (resetb=0 at a clk_in edge):
  - D = S = DEF_DIV, P = 0, cnt = DEF_DIV-1.
  - clk_out = 0, tick = 0, pending = 0.
  - Reset dominates every other input.
- Priority per edge: resetb > sync > en.
- H = ceil(D/2) = high-phase length in clk_in cycles.
  - Even D: high D/2 cycles, low D/2 cycles.
  - Odd D: high (D+1)/2 cycles, low (D-1)/2 cycles.
- Enabled edge (en=1, sync=0):
  - If cnt == D-1 (wrap): cnt <= 0. If P=1, D <= S and P <= 0; the new D governs this new period, including its H.
  - Otherwise: cnt <= cnt+1.
  - clk_out <= (new cnt < H of the divisor in effect for the new cnt).
  - tick <= 1 iff new cnt == 0, else 0.
- First enabled edge after reset wraps: clk_out rises and tick=1 on that edge. Period is D clk_in cycles thereafter.
- en=0 (sync=0):
  - cnt, clk_out, D, P are held; tick <= 0.
  - load is still accepted.
  - Resuming continues from the held phase.
- load=1:
  - Each S <= max(div_in slice, 2); values 0 and 1 clamp to 2. All P <= 1.
  - A load on the same edge as a wrap is not applied at that wrap; it applies at the next wrap.
  - A second load while pending overwrites S. Only the latest value is used.
- sync=1 (any en):
  - Every channel: if P=1 then D <= S and P <= 0. cnt <= 0, clk_out <= 1, tick <= 1.
  - A simultaneous load captures into S, sets P=1, and is applied at the next wrap, not this sync.
  - After sync, channels with D_a, D_b produce coincident ticks every lcm(D_a, D_b) cycles.
- Latency:
  - clk_out and tick change on the same edge as the cnt update.
  - load to pending=1 takes 1 cycle.
- No combinational path from any input to any output; clk_in is never passed through (minimum D = 2).
- Counter arithmetic is modulo D only; cnt never exceeds D-1 because D changes only at wrap or sync, where cnt becomes 0.

Test Plan:
- Reset, then en=1, no load: ch0/ch1 clk_out rise on the first enabled edge with tick=1. Period is 64 cycles, high 32/low 32, and tick recurs every 64 cycles.
- load div_in = {ch1=5, ch0=4}, then sync:
  - ch0 pattern is 1,1,0,0 repeating.
  - ch1 pattern is 1,1,1,0,0 repeating.
  - Ticks coincide every 20 cycles.
- With D=6 running, load 10 at cnt=2: pending=1 for the remaining 3 cycles. At the wrap, pending=0 and the next period is 10 cycles (5 high/5 low). The old period is not truncated.
- Load 0 and 1: both clamp to 2. clk_out toggles every cycle and tick is asserted every 2nd cycle. Load coincident with a wrap defers to the following wrap.
- en deasserted for 7 cycles mid-high phase: clk_out and cnt are frozen and tick=0. After resume, the remaining phase length equals the pre-freeze remainder.
- resetb pulsed low mid-period while pending=1: the next edge shows clk_out=0, tick=0, pending=0, and D=64. The loaded value is discarded.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel divide-by-D with ~50% duty and rising-edge tick.
// Divisor changes are staged in a shadow register and applied only at a period wrap or a global sync.
module clk_div_multi #(
  parameter int NCH     = 2,
  parameter int CW      = 8,
  parameter int DEF_DIV = 64
) (
  input  logic              clk_in,
  input  logic              resetb,
  input  logic              en,
  input  logic              sync,
  input  logic              load,
  input  logic [NCH*CW-1:0] div_in,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending
);

  localparam logic [CW-1:0] DEF_D   = CW'(DEF_DIV);
  localparam logic [CW-1:0] DEF_CNT = CW'(DEF_DIV - 1);
  localparam logic [CW-1:0] MIN_D   = CW'(2);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] div_q, shd_q, cnt_q;
    logic [CW-1:0] div_nx, shd_nx, cnt_nx, slice;
    logic [CW:0]   half;
    logic          pend_q, clk_q, tick_q;
    logic          pend_nx, clk_nx, tick_nx, wrap;

    always_comb begin
      slice   = div_in[i*CW +: CW];
      wrap    = (cnt_q == div_q - CW'(1));
      div_nx  = div_q;
      shd_nx  = shd_q;
      pend_nx = pend_q;
      cnt_nx  = cnt_q;
      clk_nx  = clk_q;
      tick_nx = 1'b0;

      if (sync) begin
        if (pend_q) begin
          div_nx  = shd_q;
          pend_nx = 1'b0;
        end
        cnt_nx = '0;
      end else if (en) begin
        if (wrap) begin
          cnt_nx = '0;
          if (pend_q) begin
            div_nx  = shd_q;
            pend_nx = 1'b0;
          end
        end else begin
          cnt_nx = cnt_q + CW'(1);
        end
      end

      // High phase is ceil(D/2) of whichever divisor governs the new count.
      half = ({1'b0, div_nx} + (CW+1)'(1)) >> 1;
      if (sync || en) begin
        clk_nx  = ({1'b0, cnt_nx} < half);
        tick_nx = (cnt_nx == '0);
      end

      // A load lands after any wrap/sync update, so it always waits for the next boundary.
      if (load) begin
        shd_nx  = (slice < MIN_D) ? MIN_D : slice;
        pend_nx = 1'b1;
      end
    end

    always_ff @(posedge clk_in) begin
      if (!resetb) begin
        div_q  <= DEF_D;
        shd_q  <= DEF_D;
        pend_q <= 1'b0;
        cnt_q  <= DEF_CNT;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_nx;
        shd_q  <= shd_nx;
        pend_q <= pend_nx;
        cnt_q  <= cnt_nx;
        clk_q  <= clk_nx;
        tick_q <= tick_nx;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios against hand-derived constants, plus
// randomized traffic against a period-position reference model.
module tb_clk_div_multi;
  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DEF = 64;

  logic              clk_in = 1'b0;
  logic              resetb = 1'b0;
  logic              en     = 1'b0;
  logic              sync   = 1'b0;
  logic              load   = 1'b0;
  logic [NCH*CW-1:0] div_in = '0;
  logic [NCH-1:0]    clk_out, tick, pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: each channel is a period of length m_d, position m_pos within it.
  int m_d[NCH], m_s[NCH], m_p[NCH], m_pos[NCH], m_clk[NCH], m_tick[NCH];

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF)) dut (
    .clk_in (clk_in),
    .resetb (resetb),
    .en     (en),
    .sync   (sync),
    .load   (load),
    .div_in (div_in),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    for (int ch = 0; ch < NCH; ch++) begin
      if (!resetb) begin
        m_d[ch] = DEF; m_s[ch] = DEF; m_p[ch] = 0;
        m_pos[ch] = DEF - 1; m_clk[ch] = 0; m_tick[ch] = 0;
      end else begin
        if (sync) begin
          if (m_p[ch] != 0) begin m_d[ch] = m_s[ch]; m_p[ch] = 0; end
          m_pos[ch] = 0;
          m_clk[ch] = 1;
          m_tick[ch] = 1;
        end else if (en) begin
          m_pos[ch] = m_pos[ch] + 1;
          if (m_pos[ch] >= m_d[ch]) begin
            m_pos[ch] = 0;
            if (m_p[ch] != 0) begin m_d[ch] = m_s[ch]; m_p[ch] = 0; end
          end
          m_clk[ch]  = (m_pos[ch] < (m_d[ch] + 1) / 2) ? 1 : 0;
          m_tick[ch] = (m_pos[ch] == 0) ? 1 : 0;
        end else begin
          m_tick[ch] = 0;
        end
        if (load) begin
          int v;
          v = int'(div_in[ch*CW +: CW]);
          m_s[ch] = (v < 2) ? 2 : v;
          m_p[ch] = 1;
        end
      end
    end
    #1;
  endtask

  function automatic logic [NCH-1:0] exp_clk();
    for (int ch = 0; ch < NCH; ch++) exp_clk[ch] = (m_clk[ch] != 0);
  endfunction
  function automatic logic [NCH-1:0] exp_tick();
    for (int ch = 0; ch < NCH; ch++) exp_tick[ch] = (m_tick[ch] != 0);
  endfunction
  function automatic logic [NCH-1:0] exp_pend();
    for (int ch = 0; ch < NCH; ch++) exp_pend[ch] = (m_p[ch] != 0);
  endfunction

  task automatic test_reset();
    resetb = 0; en = 0; sync = 0; load = 0; div_in = '0;
    step(); step();
    // Reset must dominate sync/en/load.
    en = 1; sync = 1; load = 1; div_in = {8'd5, 8'd4};
    step();
    en = 0; sync = 0; load = 0;
    n_cmp++; if (clk_out !== 2'b00) begin n_bad++; $display("FAIL reset_clk got=%b exp=00", clk_out); end
    n_cmp++; if (tick !== 2'b00) begin n_bad++; $display("FAIL reset_tick got=%b exp=00", tick); end
    n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL reset_pending got=%b exp=00", pending); end
  endtask

  task automatic test_default();
    int hi, nt0, nt1, first;
    resetb = 1; en = 1;
    step();
    n_cmp++; if (clk_out !== 2'b11) begin n_bad++; $display("FAIL first_edge_clk got=%b exp=11", clk_out); end
    n_cmp++; if (tick !== 2'b11) begin n_bad++; $display("FAIL first_edge_tick got=%b exp=11", tick); end
    hi = 1; nt0 = 0; nt1 = 0; first = -1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k < 64 && clk_out[0]) hi++;
      if (tick[0]) begin nt0++; if (first < 0) first = k; end
      if (tick[1]) nt1++;
    end
    n_cmp++; if (hi != 32) begin n_bad++; $display("FAIL def_high got=%0d exp=32", hi); end
    n_cmp++; if (first != 64) begin n_bad++; $display("FAIL def_period got=%0d exp=64", first); end
    n_cmp++; if (nt0 != 2 || nt1 != 2) begin n_bad++; $display("FAIL def_ticks got=%0d/%0d exp=2/2", nt0, nt1); end
  endtask

  task automatic test_sync_pattern();
    int e0, e1, nco, second;
    div_in = {8'd5, 8'd4}; load = 1;
    step();
    load = 0;
    n_cmp++; if (pending !== 2'b11) begin n_bad++; $display("FAIL load_pending got=%b exp=11", pending); end
    sync = 1;
    step();
    sync = 0;
    e0 = 0; e1 = 0; nco = 0; second = -1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      if (clk_out[0] !== ((i % 4) < 2)) e0++;
      if (clk_out[1] !== ((i % 5) < 3)) e1++;
      if (tick === 2'b11) begin nco++; if (i > 0 && second < 0) second = i; end
    end
    n_cmp++; if (e0 != 0) begin n_bad++; $display("FAIL pat_d4 got=%0d errors exp=0", e0); end
    n_cmp++; if (e1 != 0) begin n_bad++; $display("FAIL pat_d5 got=%0d errors exp=0", e1); end
    n_cmp++; if (nco != 2 || second != 20) begin n_bad++; $display("FAIL coincide got=%0d@%0d exp=2@20", nco, second); end
    n_cmp++; if (pending !== 2'b00) begin n_bad++; $display("FAIL sync_pending got=%b exp=00", pending); end
  endtask

  task automatic test_pending_defer();
    int pc, hi, nt;
    div_in = {8'd6, 8'd6}; load = 1;
    step();
    load = 0; sync = 1;
    step();
    sync = 0;
    step(); step();
    div_in = {8'd10, 8'd10}; load = 1;
    step();
    load = 0;
    pc = pending[0] ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (!pending[0]) break;
      pc++;
    end
    n_cmp++; if (pc != 3) begin n_bad++; $display("FAIL pend_len got=%0d exp=3", pc); end
    n_cmp++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin n_bad++; $display("FAIL pend_wrap got=%b%b exp=11", tick[0], clk_out[0]); end
    hi = 1; nt = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (clk_out[0]) hi++;
      if (tick[0]) nt++;
    end
    n_cmp++; if (hi != 5 || nt != 0) begin n_bad++; $display("FAIL new_period got=hi%0d/t%0d exp=hi5/t0", hi, nt); end
    step();
    n_cmp++; if (tick[0] !== 1'b1) begin n_bad++; $display("FAIL new_period_end got=%b exp=1", tick[0]); end
  endtask

  task automatic test_clamp();
    int errs;
    div_in = {8'd1, 8'd0}; load = 1;
    step();
    load = 0; sync = 1;
    step();
    sync = 0;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (clk_out !== ((i % 2 == 0) ? 2'b11 : 2'b00)) errs++;
      if (tick !== ((i % 2 == 0) ? 2'b11 : 2'b00)) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL clamp_toggle got=%0d errors exp=0", errs); end
    // Load on the wrap edge: D=2 keeps running one more period, then D=3.
    div_in = {8'd3, 8'd3}; load = 1;
    step();
    load = 0;
    n_cmp++; if (tick !== 2'b11 || pending !== 2'b11) begin n_bad++; $display("FAIL wrap_load got=t%b/p%b exp=t11/p11", tick, pending); end
    step();
    step();
    n_cmp++; if (tick !== 2'b11 || pending !== 2'b00) begin n_bad++; $display("FAIL wrap_apply got=t%b/p%b exp=t11/p00", tick, pending); end
    step(); step();
    n_cmp++; if (clk_out !== 2'b00) begin n_bad++; $display("FAIL d3_low got=%b exp=00", clk_out); end
    step();
    n_cmp++; if (tick !== 2'b11) begin n_bad++; $display("FAIL d3_period got=%b exp=11", tick); end
  endtask

  task automatic test_freeze();
    int errs, hi, lo;
    div_in = {8'd10, 8'd10}; load = 1;
    step();
    load = 0; sync = 1;
    step();
    sync = 0;
    step(); step();
    en = 0; errs = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin div_in = {8'd4, 8'd4}; load = 1; end
      step();
      load = 0;
      if (clk_out !== 2'b11 || tick !== 2'b00) errs++;
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL freeze_hold got=%0d errors exp=0", errs); end
    n_cmp++; if (pending !== 2'b11) begin n_bad++; $display("FAIL freeze_load got=%b exp=11", pending); end
    en = 1; hi = 0; lo = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (clk_out[0]) hi++; else break;
    end
    n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL freeze_remain got=%0d exp=2", hi); end
    lo = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!clk_out[0]) lo++; else break;
    end
    n_cmp++; if (lo != 5 || tick[0] !== 1'b1 || pending[0] !== 1'b0) begin
      n_bad++; $display("FAIL freeze_low got=lo%0d/t%b/p%b exp=lo5/t1/p0", lo, tick[0], pending[0]);
    end
  endtask

  task automatic test_reset_mid();
    int gap;
    div_in = {8'd20, 8'd20}; load = 1;
    step();
    load = 0;
    step(); step();
    n_cmp++; if (pending !== 2'b11) begin n_bad++; $display("FAIL pre_reset_pend got=%b exp=11", pending); end
    resetb = 0;
    step();
    resetb = 1; en = 0;
    n_cmp++; if (clk_out !== 2'b00 || tick !== 2'b00 || pending !== 2'b00) begin
      n_bad++; $display("FAIL mid_reset got=c%b/t%b/p%b exp=c00/t00/p00", clk_out, tick, pending);
    end
    en = 1;
    step();
    gap = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (tick[0]) begin gap = k; break; end
    end
    n_cmp++; if (gap != 64) begin n_bad++; $display("FAIL post_reset_period got=%0d exp=64", gap); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      resetb = ($urandom_range(0, 499) != 0);
      en     = ($urandom_range(0, 9) != 0);
      sync   = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 19) == 0);
      for (int ch = 0; ch < NCH; ch++)
        div_in[ch*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 255))
                                                          : CW'($urandom_range(0, 12));
      step();
      n_cmp++; if (clk_out !== exp_clk()) begin n_bad++; $display("FAIL rand_clk cyc=%0d got=%b exp=%b", c, clk_out, exp_clk()); end
      n_cmp++; if (tick !== exp_tick()) begin n_bad++; $display("FAIL rand_tick cyc=%0d got=%b exp=%b", c, tick, exp_tick()); end
      n_cmp++; if (pending !== exp_pend()) begin n_bad++; $display("FAIL rand_pend cyc=%0d got=%b exp=%b", c, pending, exp_pend()); end
    end
    resetb = 1; en = 0; sync = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_sync_pattern();
    test_pending_defer();
    test_clamp();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
